onehot_encoder_6_3: RTL and testbench



---
 rtl/onehot_encoder_6_3.sv | 88 ++++++++
 tb/tb_onehot_encoder_6_3.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_6_3.sv
// Pending-request collector that emits one binary index per valid/ready handshake.
// Build with ONEHOT_ENC_ROUND_ROBIN_EN defined for round-robin selection; the default is fixed lowest-index priority.
module onehot_encoder_6_3 #(
  parameter int N_IN  = 6,
  parameter int W_OUT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req,
  input  logic             req_valid,
  output logic [W_OUT-1:0] code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [N_IN-1:0]  pending,
  output logic             lost
);

  // Handshake: code/code_valid are driven combinationally from pending. A code
  // transfers on a rising edge where code_valid && code_ready, and its pending
  // bit clears on that same edge. code_ready with code_valid=0 does nothing.

  logic [N_IN-1:0]  pending_q;
  logic [N_IN-1:0]  served_onehot;
  logic [N_IN-1:0]  req_masked;
  logic [N_IN-1:0]  pending_next;
  logic             lost_q;
  logic             lost_next;
  logic             handshake;
  logic [W_OUT-1:0] sel_idx;

  function automatic logic [W_OUT-1:0] lowest_set(input logic [N_IN-1:0] v);
    logic [W_OUT-1:0] idx;
    idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (v[i]) idx = W_OUT'(i);
    end
    return idx;
  endfunction

`ifdef ONEHOT_ENC_ROUND_ROBIN_EN
  logic [W_OUT-1:0] ptr_q;
  logic [N_IN-1:0]  above_ptr;

  // Bits strictly above the last served index get first chance; otherwise wrap.
  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < N_IN; i++) begin
      above_ptr[i] = (i > int'(ptr_q));
    end
    if (|(pending_q & above_ptr)) sel_idx = lowest_set(pending_q & above_ptr);
    else                          sel_idx = lowest_set(pending_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ptr_q <= W_OUT'(N_IN - 1);
    else if (handshake) ptr_q <= sel_idx;
  end
`else
  always_comb begin
    sel_idx = lowest_set(pending_q);
  end
`endif

  always_comb begin
    code_valid    = |pending_q;
    code          = code_valid ? sel_idx : '0;
    handshake     = code_valid && code_ready;
    served_onehot = handshake ? (N_IN'(1) << sel_idx) : '0;
    req_masked    = req_valid ? req : '0;
    pending_next  = (pending_q & ~served_onehot) | req_masked;
    // A bit being served this edge may be re-requested without loss.
    lost_next     = |(req_masked & pending_q & ~served_onehot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      lost_q    <= 1'b0;
    end else begin
      pending_q <= pending_next;
      lost_q    <= lost_next;
    end
  end

  assign pending = pending_q;
  assign lost    = lost_q;

endmodule

// File: tb/tb_onehot_encoder_6_3.sv
// Directed bench for onehot_encoder_6_3 (default fixed-priority build).
// Expected codes are queued by the driver and checked by a monitor on each handshake.
module tb_onehot_encoder_6_3;

  logic       clk;
  logic       rst_n;
  logic [5:0] req;
  logic       req_valid;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [5:0] pending;
  logic       lost;

  logic [2:0] exp_q[$];
  int n_cmp;
  int n_bad;

  onehot_encoder_6_3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_valid  (req_valid),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pending    (pending),
    .lost       (lost)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && code_valid && code_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL code_unexpected: got %0d with empty queue at %0t", code, $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (code !== e) begin
          n_bad++;
          $display("FAIL code: got %0d expected %0d at %0t", code, e, $time);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req = '0;
    req_valid = 1'b0;
    code_ready = 1'b0;
    #12;
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_code_valid", 32'(code_valid), 32'h0);
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_lost", 32'(lost), 32'h0);
    rst_n = 1'b1;
    step();

    // empty request loads nothing
    req = 6'b000000; req_valid = 1'b1; code_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      mid();
      chk("empty_valid", 32'(code_valid), 32'h0);
      chk("empty_code", 32'(code), 32'h0);
      chk("empty_lost", 32'(lost), 32'h0);
    end

    // two bits served in priority order
    step();
    req = 6'b100100; req_valid = 1'b1; code_ready = 1'b1;
    exp_q.push_back(3'd2); exp_q.push_back(3'd5);
    step();
    req_valid = 1'b0;
    mid(); chk("t2_pend0", 32'(pending), 32'b100100);
    step();
    mid(); chk("t2_pend1", 32'(pending), 32'b100000);
    step();
    mid(); chk("t2_pend2", 32'(pending), 32'b000000);
    chk("t2_valid", 32'(code_valid), 32'h0);

    // hold under backpressure, higher priority preempts
    step();
    code_ready = 1'b0; req = 6'b000010; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("t3_hold", 32'(code), 32'd1);
      chk("t3_hold_valid", 32'(code_valid), 32'h1);
      step();
    end
    req = 6'b000001; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    mid(); chk("t3_preempt", 32'(code), 32'd0);
    chk("t3_pend", 32'(pending), 32'b000011);
    step();
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    code_ready = 1'b1;
    step(); step();
    mid(); chk("t3_empty", 32'(pending), 32'h0);

    // lost on re-request of an unserved bit
    step();
    code_ready = 1'b0; req = 6'b001000; req_valid = 1'b1;
    step(); step();
    req_valid = 1'b0;
    mid(); chk("t4_lost", 32'(lost), 32'h1);
    chk("t4_pend", 32'(pending), 32'b001000);
    step();
    mid(); chk("t4_lost_pulse", 32'(lost), 32'h0);
    // same re-request while being served: no loss, bit stays
    step();
    exp_q.push_back(3'd3);
    req_valid = 1'b1; code_ready = 1'b1;
    step();
    req_valid = 1'b0; code_ready = 1'b0;
    mid(); chk("t4_nolost", 32'(lost), 32'h0);
    chk("t4_kept", 32'(pending), 32'b001000);
    step();
    exp_q.push_back(3'd3);
    code_ready = 1'b1;
    step();
    mid(); chk("t4_clear", 32'(pending), 32'h0);

    // fixed priority: bit 0 arrives while bit 5 is served
    step();
    code_ready = 1'b0; req = 6'b100000; req_valid = 1'b1;
    step();
    exp_q.push_back(3'd5);
    req = 6'b100001; code_ready = 1'b1;
    step();
    req_valid = 1'b0;
    exp_q.push_back(3'd0); exp_q.push_back(3'd5);
    mid(); chk("t5_pend", 32'(pending), 32'b100001);
    chk("t5_lost", 32'(lost), 32'h0);
    step(); step();
    mid(); chk("t5_empty", 32'(code_valid), 32'h0);

    // full: one code per cycle in index order
    step();
    req = 6'b111111; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(3'(i));
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    mid(); chk("t6_empty", 32'(pending), 32'h0);

    // asynchronous reset mid-cycle with lost pending
    step();
    code_ready = 1'b0; req = 6'b011011; req_valid = 1'b1;
    step();
    req = 6'b000001;
    step();
    req_valid = 1'b0;
    #1;
    chk("t7_pre_pend", 32'(pending), 32'b011011);
    chk("t7_pre_lost", 32'(lost), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_pend", 32'(pending), 32'h0);
    chk("t7_rst_valid", 32'(code_valid), 32'h0);
    chk("t7_rst_lost", 32'(lost), 32'h0);
    req = 6'b111111; req_valid = 1'b1;
    step();
    chk("t7_hold_pend", 32'(pending), 32'h0);
    chk("t7_hold_valid", 32'(code_valid), 32'h0);
    req_valid = 1'b0;
    mid();
    rst_n = 1'b1;
    step();
    mid(); chk("t7_after", 32'(pending), 32'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
